alu_arbiter: RTL and testbench

Shares one 32-bit `alu` datapath between two requesters. Each requester sends an operation (a, b, f) over a valid/ready handshake. The arbiter grants one request at a time with round-robin or fixed priority, and registers the operands into the ALU. It captures the ALU result and carry, and returns them on a single response channel tagged with the requester id, which is held until the consumer accepts it.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter : two-requester arbiter sharing one registered 32-bit ALU
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

//------------------------------------------------------------------------------
// alu : AND/OR/ADD/SLT with optional b inversion and carry-in from f[2]
//------------------------------------------------------------------------------
module alu (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_f,
    output logic [31:0] o_y,
    output logic        o_c
);

    logic [31:0] w_bm;
    logic [32:0] w_sum;

    always_comb begin
        w_bm  = i_f[2] ? ~i_b : i_b;
        w_sum = {1'b0, i_a} + {1'b0, w_bm} + {32'd0, i_f[2]};
        o_c   = w_sum[32];
        case (i_f[1:0])
            2'b00:   o_y = i_a & w_bm;
            2'b01:   o_y = i_a | w_bm;
            2'b10:   o_y = w_sum[31:0];
            default: o_y = {31'd0, w_sum[31]};
        endcase
    end

endmodule

//------------------------------------------------------------------------------
// alu_arbiter : top level
//------------------------------------------------------------------------------
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [2:0]  i_req0_f,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    input  logic [2:0]  i_req1_f,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_id,
    output logic [31:0] o_rsp_y,
    output logic        o_rsp_c,
    output logic        o_busy
);

    localparam logic c_rr = (RR_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ptr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_f;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic [31:0] w_alu_y;
    logic        w_alu_c;

    // Readies are gated by reset so nothing is offered while the block is held in reset
    always_comb begin
        w_idle   = i_rstn && (r_state == ST_IDLE);
        w_grant1 = i_req1_valid && (!i_req0_valid || (c_rr && r_ptr));
        w_grant0 = i_req0_valid && !w_grant1;
    end

    assign o_req0_ready = w_idle && w_grant0;
    assign o_req1_ready = w_idle && w_grant1;
    assign o_busy       = (r_state != ST_IDLE);

    alu u_alu (
        .i_a (r_a),
        .i_b (r_b),
        .i_f (r_f),
        .o_y (w_alu_y),
        .o_c (w_alu_c)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_f         <= 3'd0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= 1'b0;
            o_rsp_y     <= 32'd0;
            o_rsp_c     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (o_req0_ready || o_req1_ready) begin
                        r_a      <= w_grant1 ? i_req1_a : i_req0_a;
                        r_b      <= w_grant1 ? i_req1_b : i_req0_b;
                        r_f      <= w_grant1 ? i_req1_f : i_req0_f;
                        o_rsp_id <= w_grant1;
                        if (c_rr) begin
                            r_ptr <= ~w_grant1;
                        end
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_rsp_y     <= w_alu_y;
                    o_rsp_c     <= w_alu_c;
                    o_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// tb_alu_arbiter : self-checking bench for round-robin and fixed-priority builds
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;          // 0 drives the round-robin instance, 1 the fixed-priority one
    logic        v0, v1, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  f0, f1;

    logic        rr_r0, rr_r1, rr_rv, rr_id, rr_c, rr_busy;
    logic [31:0] rr_y;
    logic        fp_r0, fp_r1, fp_rv, fp_id, fp_c, fp_busy;
    logic [31:0] fp_y;

    logic        ready0, ready1, rsp_valid, rsp_id, rsp_c, busy;
    logic [31:0] rsp_y;

    int   total  = 0;
    int   passed = 0;
    logic ptr_m;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1)) dut_rr (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0 && !sel), .o_req0_ready(rr_r0),
        .i_req0_a(a0), .i_req0_b(b0), .i_req0_f(f0),
        .i_req1_valid(v1 && !sel), .o_req1_ready(rr_r1),
        .i_req1_a(a1), .i_req1_b(b1), .i_req1_f(f1),
        .o_rsp_valid(rr_rv), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rr_id), .o_rsp_y(rr_y), .o_rsp_c(rr_c), .o_busy(rr_busy)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(v0 && sel), .o_req0_ready(fp_r0),
        .i_req0_a(a0), .i_req0_b(b0), .i_req0_f(f0),
        .i_req1_valid(v1 && sel), .o_req1_ready(fp_r1),
        .i_req1_a(a1), .i_req1_b(b1), .i_req1_f(f1),
        .o_rsp_valid(fp_rv), .i_rsp_ready(rsp_ready),
        .o_rsp_id(fp_id), .o_rsp_y(fp_y), .o_rsp_c(fp_c), .o_busy(fp_busy)
    );

    assign ready0    = sel ? fp_r0   : rr_r0;
    assign ready1    = sel ? fp_r1   : rr_r1;
    assign rsp_valid = sel ? fp_rv   : rr_rv;
    assign rsp_id    = sel ? fp_id   : rr_id;
    assign rsp_y     = sel ? fp_y    : rr_y;
    assign rsp_c     = sel ? fp_c    : rr_c;
    assign busy      = sel ? fp_busy : rr_busy;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference ALU: plain 33-bit arithmetic on a + (b or ~b) + f[2]
    task automatic alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                           output logic [31:0] y, output logic c);
        logic [31:0] bm;
        logic [32:0] s;
        bm = f[2] ? ~b : b;
        s  = 33'(a) + 33'(bm) + 33'(f[2]);
        c  = s[32];
        case (f[1:0])
            2'b00:   y = a & bm;
            2'b01:   y = a | bm;
            2'b10:   y = s[31:0];
            default: y = s[31] ? 32'd1 : 32'd0;
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input logic id);
        if (id) begin
            a1 = $urandom; b1 = $urandom; f1 = 3'($urandom_range(0, 7));
        end else begin
            a0 = $urandom; b0 = $urandom; f0 = 3'($urandom_range(0, 7));
        end
    endtask

    // Expected winner from the arbitration rules, then checks the readies
    task automatic grant(output logic w, output logic [31:0] ey, output logic ec);
        #1;
        if (v0 && v1) w = sel ? 1'b0 : ptr_m;
        else          w = v1;
        chk1("ready0", ready0, !w);
        chk1("ready1", ready1, w);
        if (!sel) ptr_m = ~w;
        if (w) alu_ref(a1, b1, f1, ey, ec);
        else   alu_ref(a0, b0, f0, ey, ec);
    endtask

    // Runs EXEC and RESP after a grant; returns at IDLE, 1 time unit after the edge
    task automatic complete(input logic w, input logic [31:0] ey, input logic ec,
                            input int stall, input bit refill, input bit raise);
        rsp_ready = (stall == 0);
        tick;
        if (refill)  rand_payload(w);
        else if (w)  v1 = 1'b0;
        else         v0 = 1'b0;
        #1;
        chk1("exec_busy", busy, 1'b1);
        chk1("exec_ready0", ready0, 1'b0);
        chk1("exec_ready1", ready1, 1'b0);
        chk1("exec_rsp_valid", rsp_valid, 1'b0);
        tick;
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk1("rsp_id", rsp_id, w);
        chk32("rsp_y", rsp_y, ey);
        chk1("rsp_c", rsp_c, ec);
        if (raise) begin
            rand_payload(1'b0); rand_payload(1'b1);
            v0 = 1'b1; v1 = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            tick;
            chk1("hold_valid", rsp_valid, 1'b1);
            chk1("hold_id", rsp_id, w);
            chk32("hold_y", rsp_y, ey);
            chk1("hold_c", rsp_c, ec);
            chk1("hold_ready0", ready0, 1'b0);
            chk1("hold_ready1", ready1, 1'b0);
        end
        rsp_ready = 1'b1;
        tick;
        chk1("idle_rsp_valid", rsp_valid, 1'b0);
        chk1("idle_busy", busy, 1'b0);
    endtask

    task automatic run_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f, input int stall, input bit raise);
        logic        w, ec;
        logic [31:0] ey;
        v0 = 1'b0; v1 = 1'b0;
        if (id) begin a1 = a; b1 = b; f1 = f; v1 = 1'b1; end
        else    begin a0 = a; b0 = b; f0 = f; v0 = 1'b1; end
        grant(w, ey, ec);
        complete(w, ey, ec, stall, 1'b0, raise);
    endtask

    task automatic run_contend(input int n);
        logic        w, ec;
        logic [31:0] ey;
        rand_payload(1'b0); rand_payload(1'b1);
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < n; k++) begin
            grant(w, ey, ec);
            complete(w, ey, ec, 0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w, ec;
        logic [31:0] ey;

        sel = 1'b0; rstn = 1'b0; rsp_ready = 1'b0; ptr_m = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        a0 = '0; b0 = '0; f0 = '0; a1 = '0; b1 = '0; f1 = '0;
        #3;
        chk1("rst_ready0", ready0, 1'b0);
        chk1("rst_ready1", ready1, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_rsp_y", rsp_y, 32'd0);
        chk1("rst_rsp_c", rsp_c, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        v0 = 1'b0; v1 = 1'b0;
        tick;
        rstn = 1'b1;
        tick;

        // Round-robin contention: ids must alternate 0,1,0,1 from reset
        run_contend(4);
        v0 = 1'b0; v1 = 1'b0;

        // Directed operations
        run_single(1'b0, 32'd5, 32'd3, 3'b010, 0, 1'b0);
        chk32("add_5_3", rsp_y, 32'd8);
        run_single(1'b1, 32'd3, 32'd5, 3'b111, 0, 1'b0);
        chk32("slt_3_5", rsp_y, 32'd1);
        run_single(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 0, 1'b0);
        chk32("add_wrap_y", rsp_y, 32'd0);
        chk1("add_wrap_c", rsp_c, 1'b1);
        run_single(1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 3'b000, 0, 1'b0);
        run_single(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 3'b101, 1, 1'b0);
        run_single(1'b0, 32'd10, 32'd10, 3'b110, 0, 1'b0);

        // Random operations with occasional backpressure
        for (int k = 0; k < 16; k++) begin
            run_single(1'($urandom_range(0, 1)), $urandom, $urandom,
                       3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Backpressure with both requesters waiting, then drain them
        run_single(1'b0, $urandom, $urandom, 3'b010, 5, 1'b1);
        grant(w, ey, ec);
        complete(w, ey, ec, 0, 1'b0, 1'b0);
        grant(w, ey, ec);
        complete(w, ey, ec, 0, 1'b0, 1'b0);

        // Reset during EXEC: pointer returns to requester 0, nothing stale comes out
        a0 = 32'd7; b0 = 32'd9; f0 = 3'b010; v0 = 1'b1; v1 = 1'b0;
        grant(w, ey, ec);
        rsp_ready = 1'b0;
        tick;
        v0 = 1'b0;
        chk1("pre_rst_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk32("midrst_rsp_y", rsp_y, 32'd0);
        chk1("midrst_rsp_c", rsp_c, 1'b0);
        chk1("midrst_rsp_id", rsp_id, 1'b0);
        chk1("midrst_ready0", ready0, 1'b0);
        ptr_m = 1'b0;
        tick;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk1("post_rst_busy", busy, 1'b0);
        end
        rand_payload(1'b0); rand_payload(1'b1);
        v0 = 1'b1; v1 = 1'b1;
        grant(w, ey, ec);
        complete(w, ey, ec, 0, 1'b0, 1'b0);
        grant(w, ey, ec);
        complete(w, ey, ec, 0, 1'b0, 1'b0);

        // Fixed priority instance: requester 0 always wins while valid
        sel = 1'b1;
        run_contend(4);
        v0 = 1'b0;
        grant(w, ey, ec);
        complete(w, ey, ec, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_single(1'($urandom_range(0, 1)), $urandom, $urandom,
                       3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
